// File: rtl/key_schedule_gen_if.sv
// Bundles the key-expansion request inputs and the schedule/status outputs.
// The requester drives start/Nk/cipherKey through the master modport;
// the expansion engine owns the slave side.
interface key_schedule_gen_if;
    logic          start;
    logic [7:0]    Nk;
    logic [255:0]  cipherKey;
    logic [1919:0] keySchedule;
    logic          busy;
    logic          doneFlag;

    modport master (
        output start, Nk, cipherKey,
        input  keySchedule, busy, doneFlag
    );

    modport slave (
        input  start, Nk, cipherKey,
        output keySchedule, busy, doneFlag
    );
endinterface

// File: rtl/key_schedule_gen.sv
// Iterative AES key expansion: loads a 128/192/256-bit key and emits one
// 32-bit schedule word per clock into a packed 1920-bit register, then
// holds the finished schedule with doneFlag high until the next start.
module key_schedule_gen (
    input  logic               clk,
    input  logic               reset,
    key_schedule_gen_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    // Shared AES S-box, byte x lives at bits [8*(255-x) +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_t        state_q, state_d;
    logic [1919:0] ks_q;
    logic [5:0]    i_q, i_d;
    logic [2:0]    m_q, m_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [3:0]    nk_q, nk_d;

    logic [3:0]    nkSel;
    logic [255:0]  keyMask;
    logic [5:0]    lastIdx;
    logic [10:0]   prevLsb, backLsb, curLsb;
    logic [31:0]   wPrev, wBack, temp, newWord;
    logic          load, wrEn;

    // Decode the requested key length; anything unrecognised behaves as 8 words.
    always_comb begin
        nkSel   = 4'd8;
        keyMask = '1;
        if (bus.Nk == 8'd4) begin
            nkSel   = 4'd4;
            keyMask = {{128{1'b1}}, 128'b0};
        end else if (bus.Nk == 8'd6) begin
            nkSel   = 4'd6;
            keyMask = {{192{1'b1}}, 64'b0};
        end
    end

    // Locate w[i-1], w[i-Nk] and w[i] inside the packed schedule and pick the final word index.
    always_comb begin
        prevLsb = {6'd60 - i_q, 5'b0};
        curLsb  = {6'd59 - i_q, 5'b0};
        backLsb = {6'd59 - (i_q - {2'b00, nk_q}), 5'b0};
        wPrev   = ks_q[prevLsb +: 32];
        wBack   = ks_q[backLsb +: 32];
        case (nk_q)
            4'd4:    lastIdx = 6'd43;
            4'd6:    lastIdx = 6'd51;
            default: lastIdx = 6'd59;
        endcase
    end

    // Next-state logic: accept start when idle/done, otherwise produce one word per cycle.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        m_d     = m_q;
        rcon_d  = rcon_q;
        nk_d    = nk_q;
        load    = 1'b0;
        wrEn    = 1'b0;
        temp    = wPrev;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = EXPAND;
                    nk_d    = nkSel;
                    i_d     = {2'b00, nkSel};
                    m_d     = 3'd0;
                    rcon_d  = 8'h01;
                end
            end
            EXPAND: begin
                wrEn = 1'b1;
                if (m_q == 3'd0) begin
                    temp   = subWord({wPrev[23:0], wPrev[31:24]}) ^ {rcon_q, 24'h0};
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                end else if (nk_q == 4'd8 && m_q == 3'd4) begin
                    temp = subWord(wPrev);
                end
                i_d = i_q + 6'd1;
                m_d = ({1'b0, m_q} == nk_q - 4'd1) ? 3'd0 : m_q + 3'd1;
                if (i_q == lastIdx) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        newWord = wBack ^ temp;
    end

    // Control registers: state, word index, i-mod-Nk counter, round constant and latched Nk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= 6'd0;
            m_q     <= 3'd0;
            rcon_q  <= 8'h01;
            nk_q    <= 4'd8;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            m_q     <= m_d;
            rcon_q  <= rcon_d;
            nk_q    <= nk_d;
        end
    end

    // Schedule storage: key words on load, then one derived word per expansion cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ks_q <= '0;
        end else if (load) begin
            ks_q <= {bus.cipherKey & keyMask, 1664'b0};
        end else if (wrEn) begin
            ks_q[curLsb +: 32] <= newWord;
        end
    end

    assign bus.keySchedule = ks_q;
    assign bus.busy        = (state_q == EXPAND);
    assign bus.doneFlag    = (state_q == DONE);

endmodule

// File: tb/tb_key_schedule_gen.sv
// Self-checking bench for key_schedule_gen: known-answer table, corner
// sequences (ignored start, mid-run reset, back-to-back restart) and random
// keys compared against a FIPS-197 style reference expansion.
module tb_key_schedule_gen;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        logic [7:0]   nk;
        logic [255:0] key;
        int           wordIdx;
        logic [31:0]  expWord;
        int           expCycles;
        int           zeroBits;
    } vec_t;

    logic clk;
    logic reset;
    int   compareCount;
    int   failCount;
    logic [7:0] sb [256];

    key_schedule_gen_if bus ();

    key_schedule_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Build the S-box from its definition: multiplicative inverse then affine map.
    task automatic buildSbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] refSub(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic int effNk(input logic [7:0] nkRaw);
        return (nkRaw == 8'd4) ? 4 : (nkRaw == 8'd6) ? 6 : 8;
    endfunction

    // Reference key expansion written straight from the textbook loop.
    function automatic logic [1919:0] refSchedule(input logic [7:0] nkRaw, input logic [255:0] key);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] packed_ks;
        int nk;
        int total;
        nk    = effNk(nkRaw);
        total = 4 * (nk + 7);
        for (int j = 0; j < 60; j++) w[j] = 32'h0;
        for (int j = 0; j < nk; j++) w[j] = key[255 - 32 * j -: 32];
        rc = 8'h01;
        for (int j = nk; j < total; j++) begin
            t = w[j - 1];
            if (j % nk == 0) begin
                t  = refSub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && j % nk == 4) begin
                t = refSub(t);
            end
            w[j] = w[j - nk] ^ t;
        end
        for (int j = 0; j < 60; j++) packed_ks[1919 - 32 * j -: 32] = w[j];
        return packed_ks;
    endfunction

    function automatic logic [31:0] getWord(input logic [1919:0] ks, input int j);
        return ks[1919 - 32 * j -: 32];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkSchedule(input string name, input logic [1919:0] act, input logic [1919:0] exp);
        compareCount++;
        if (act !== exp) begin
            failCount++;
            for (int j = 0; j < 60; j++) begin
                if (getWord(act, j) !== getWord(exp, j)) begin
                    $display("[TB] FAIL %s: first bad word w[%0d] got %h expected %h",
                             name, j, getWord(act, j), getWord(exp, j));
                    break;
                end
            end
        end
    endtask

    // Pulse start, then count cycles to doneFlag; optionally glitch inputs or abort early.
    task automatic applyStimulus(input logic [7:0] nk, input logic [255:0] key,
                                 input int glitchAt, input int abortAt, output int cycles);
        @(negedge clk);
        bus.Nk        = nk;
        bus.cipherKey = key;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("busyAfterStart", 32'(bus.busy), 32'd1);
        checkOutput("doneLowAfterStart", 32'(bus.doneFlag), 32'd0);
        cycles = 0;
        while (!bus.doneFlag && cycles < 200 && cycles != abortAt) begin
            @(negedge clk);
            cycles++;
            if (cycles == glitchAt) begin
                bus.start     = 1'b1;
                bus.Nk        = (nk == 8'd4) ? 8'd8 : 8'd4;
                bus.cipherKey = ~key;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        if (cycles >= 200) $display("[TB] FAIL doneTimeout: got no doneFlag after %0d cycles", cycles);
    endtask

    task automatic runAndCheck(input string tag, input logic [7:0] nk, input logic [255:0] key,
                               input int glitchAt);
        int cycles;
        int nkE;
        nkE = effNk(nk);
        applyStimulus(nk, key, glitchAt, -1, cycles);
        checkOutput({tag, "Cycles"}, 32'(cycles), 32'(4 * (nkE + 7) - nkE));
        checkOutput({tag, "BusyLowAtDone"}, 32'(bus.busy), 32'd0);
        checkSchedule({tag, "Schedule"}, bus.keySchedule, refSchedule(nk, key));
    endtask

    initial begin
        vec_t vecs [7];
        int   cycles;
        logic [7:0]   rndNk;
        logic [255:0] rndKey;

        vecs[0] = '{8'd4, K128, 4,  32'ha0fafe17, 40, 512};
        vecs[1] = '{8'd4, K128, 43, 32'hb6630ca6, 40, 512};
        vecs[2] = '{8'd6, K192, 6,  32'hfe0c91f7, 46, 256};
        vecs[3] = '{8'd6, K192, 51, 32'h01002202, 46, 256};
        vecs[4] = '{8'd8, K256, 8,  32'h9ba35411, 52, 0};
        vecs[5] = '{8'd8, K256, 12, 32'ha8b09c1a, 52, 0};
        vecs[6] = '{8'd8, K256, 59, 32'h706c631e, 52, 0};

        compareCount  = 0;
        failCount     = 0;
        clk           = 1'b0;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.Nk        = 8'd4;
        bus.cipherKey = '0;
        buildSbox();

        repeat (3) @(negedge clk);
        checkSchedule("resetSchedule", bus.keySchedule, '0);
        checkOutput("resetBusy", 32'(bus.busy), 32'd0);
        checkOutput("resetDone", 32'(bus.doneFlag), 32'd0);
        reset = 1'b1;

        // Known-answer vectors.
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].nk, vecs[v].key, 0, -1, cycles);
            checkOutput($sformatf("vec%0dCycles", v), 32'(cycles), 32'(vecs[v].expCycles));
            checkOutput($sformatf("vec%0dWord%0d", v, vecs[v].wordIdx),
                        getWord(bus.keySchedule, vecs[v].wordIdx), vecs[v].expWord);
            checkSchedule($sformatf("vec%0dSchedule", v), bus.keySchedule,
                          refSchedule(vecs[v].nk, vecs[v].key));
            if (vecs[v].zeroBits > 0) begin
                checkSchedule($sformatf("vec%0dTailZero", v),
                              bus.keySchedule << (1920 - vecs[v].zeroBits), '0);
            end
        end

        // Start pulse and input changes while expanding are ignored.
        applyStimulus(8'd4, K128, 10, -1, cycles);
        checkOutput("ignoredStartCycles", 32'(cycles), 32'd40);
        checkOutput("ignoredStartW43", getWord(bus.keySchedule, 43), 32'hb6630ca6);
        checkSchedule("ignoredStartSchedule", bus.keySchedule, refSchedule(8'd4, K128));

        // Asynchronous reset in the middle of an AES-256 expansion.
        applyStimulus(8'd8, K256, 0, 20, cycles);
        checkOutput("preResetBusy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkSchedule("midResetSchedule", bus.keySchedule, '0);
        checkOutput("midResetBusy", 32'(bus.busy), 32'd0);
        checkOutput("midResetDone", 32'(bus.doneFlag), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(8'd4, K128, 0, -1, cycles);
        checkOutput("afterResetCycles", 32'(cycles), 32'd40);
        checkOutput("afterResetW4", getWord(bus.keySchedule, 4), 32'ha0fafe17);
        checkSchedule("afterResetSchedule", bus.keySchedule, refSchedule(8'd4, K128));

        // Back-to-back restart from DONE with an out-of-range Nk.
        applyStimulus(8'h05, K256, 0, -1, cycles);
        checkOutput("nk5Cycles", 32'(cycles), 32'd52);
        checkOutput("nk5W59", getWord(bus.keySchedule, 59), 32'h706c631e);
        checkSchedule("nk5Schedule", bus.keySchedule, refSchedule(8'd8, K256));

        // Random keys and key sizes, with random input disturbance mid-run.
        for (int r = 0; r < 8; r++) begin
            for (int b = 0; b < 8; b++) rndKey[32 * b +: 32] = $urandom;
            case ($urandom_range(0, 3))
                0:       rndNk = 8'd4;
                1:       rndNk = 8'd6;
                2:       rndNk = 8'd8;
                default: rndNk = 8'($urandom);
            endcase
            runAndCheck($sformatf("rnd%0d", r), rndNk, rndKey, int'($urandom_range(0, 30)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/key_schedule_gen.md
# key_schedule_gen

Iterative AES key-expansion engine that sits directly upstream of the encryption datapath. It expands a 128/192/256-bit cipher key into the packed 1920-bit round-key schedule that the cipher consumes, producing one 32-bit word per clock. It raises `doneFlag` once the full schedule is valid, which is the cue to reset and start the cipher core.

## Interface
- No parameters; key size is selected at run time by `Nk`.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle request; sampled only in IDLE or DONE.
- `Nk`  input  8  key length in words: 4, 6 or 8; any other value is treated as 8. Latched on accepted `start`.
- `cipherKey`  input  256  key, left-aligned. AES-128 uses [255:128], AES-192 uses [255:64], AES-256 uses [255:0]. Latched on accepted `start`.
- `keySchedule`  output  1920  word w[j] at bits [1919-32j -: 32]; round key r at [1919-128r -: 128]; words beyond 4(Nr+1) are zero.
- `busy`  output  1  high in EXPAND.
- `doneFlag`  output  1  high in DONE; the schedule is complete and stable.

## Operation
- Nr = 10/12/14 and total words T = 44/52/60 for Nk = 4/6/8.
- States: IDLE, EXPAND, DONE.
- IDLE/DONE to EXPAND on `start`:
  - latch `Nk`;
  - write w[0..Nk-1] from `cipherKey` and clear all other words;
  - set i=Nk, m=0 (i mod Nk counter) and rcon=8'h01.
- EXPAND, one word per cycle:
  - temp = w[i-1].
  - If m==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <= xtime(rcon) (8'h80 to 8'h1b, reduction by 8'h1b).
  - Else if Nk==8 and m==4: temp = SubWord(temp).
  - Write w[i] = w[i-Nk] ^ temp; then i++ and m = (m==Nk-1) ? 0 : m+1.
  - No divider is allowed; use the m counter only.
- EXPAND to DONE on the edge that writes w[T-1].
- DONE holds `keySchedule` and `doneFlag` until the next `start`, which restarts from the load step.
- `start` during EXPAND is ignored; `Nk` and `cipherKey` changes after acceptance have no effect.
- SubWord applies the codebase's shared AES S-box to each byte (4 parallel lookups). RotWord is {b1,b2,b3,b0}.

## Timing
- Reset (asynchronous assert, any state, including mid-EXPAND) forces:
  - state IDLE, all words 0;
  - `busy`=0, `doneFlag`=0, i=0, m=0, rcon=8'h01.
- Release is synchronous to `clk`.
- Accepted `start` at edge k: w[0..Nk-1] are visible after edge k and `busy`=1.
- w[j] (j ≥ Nk) is visible after edge k+(j-Nk+1).
- `doneFlag` rises and `busy` falls after edge k+T-Nk: 40 cycles for AES-128, 46 for AES-192, 52 for AES-256.
- `doneFlag` drops, and `busy` rises, on the edge that accepts a new `start`.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- **AES-128:** Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse.
  - w[4]=a0fafe17 and w[43]=b6630ca6.
  - `doneFlag` rises exactly 40 cycles after start.
  - Bits [511:0] are 0.
- **AES-192:** Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - w[6]=fe0c91f7 and w[51]=01002202.
  - `doneFlag` rises after 46 cycles.
  - Bits [255:0] are 0.
- **AES-256:** Nk=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - w[8]=9ba35411, w[12]=a8b09c1a (SubWord-only path) and w[59]=706c631e.
  - `doneFlag` rises after 52 cycles.
- **Ignored start and input changes:** pulse `start` at cycle 10 of an AES-128 run and change `cipherKey`/`Nk` during EXPAND.
  - Schedule is identical to the first test.
  - Completion is still at 40 cycles.
- **Reset mid-operation:** assert `reset`=0 at cycle 20 of an AES-256 run.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release and a new AES-128 start, the result matches the first test.
- **Back-to-back and invalid Nk:**
  - `start` in DONE with Nk=8'h05 and the AES-256 key gives the same schedule as AES-256.
  - `doneFlag` drops the cycle after `start` and re-rises after 52 cycles.
